// File: rtl/data_chk.sv
// Stream packet checker: parses the header beat, counts beats against the header length,
// checks the payload ramp and issues one registered report per eop-terminated packet.
module data_chk #(
  parameter int DW          = 32,
  parameter bit CHK_PAYLOAD = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_sop,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  input  logic          i_eop,
  output logic          o_rpt_vld,
  output logic [3:0]    o_rpt_da,
  output logic [2:0]    o_rpt_prior,
  output logic [9:0]    o_rpt_len,
  output logic [10:0]   o_rpt_beats,
  output logic [3:0]    o_rpt_err,
  output logic [15:0]   o_pkt_cnt,
  output logic [15:0]   o_err_cnt,
  output logic [15:0]   o_stray_cnt
);

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  typedef struct packed {
    logic [3:0]  da;
    logic [2:0]  prior;
    logic [9:0]  len;
    logic [10:0] beats;
    logic        perr;
  } ctx_t;

  state_t      st, st_nxt;
  ctx_t        ctx_q, ctx_n;
  logic        fire, trunc, stray, mism;
  logic [3:0]  err_n;
  logic [1:0]  err_inc;
  logic [10:0] beats_inc;

  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    if (i_vld) begin
      if (i_sop)                    st_nxt = i_eop ? IDLE : BODY;
      else if (st == BODY && i_eop) st_nxt = IDLE;
    end
  end

  // ctx_n is the packet context including the current beat; a report takes it verbatim.
  always_comb begin
    ctx_n     = ctx_q;
    fire      = 1'b0;
    trunc     = 1'b0;
    stray     = 1'b0;
    mism      = 1'b0;
    beats_inc = (ctx_q.beats == 11'h7FF) ? ctx_q.beats : ctx_q.beats + 11'd1;
    if (i_vld) begin
      if (i_sop) begin
        trunc       = (st == BODY);
        ctx_n.da    = i_data[3:0];
        ctx_n.prior = i_data[6:4];
        ctx_n.len   = i_data[16:7];
        ctx_n.beats = 11'd1;
        ctx_n.perr  = 1'b0;
        fire        = i_eop;
      end else if (st == BODY) begin
        // beats before increment is this beat's index; indices >= len go unchecked
        mism        = CHK_PAYLOAD && (ctx_q.beats < {1'b0, ctx_q.len}) &&
                      (i_data != DW'(ctx_q.beats));
        ctx_n.beats = beats_inc;
        ctx_n.perr  = ctx_q.perr | mism;
        fire        = i_eop;
      end else begin
        stray = 1'b1;
      end
    end
    err_n[0] = (ctx_n.len != '0) && (ctx_n.beats < {1'b0, ctx_n.len});
    err_n[1] = (ctx_n.len != '0) && (ctx_n.beats > {1'b0, ctx_n.len});
    err_n[2] = ctx_n.perr;
    err_n[3] = (ctx_n.len == '0);
    err_inc  = {1'b0, trunc} + {1'b0, fire && (err_n != '0)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctx_q       <= '0;
      o_rpt_vld   <= 1'b0;
      o_rpt_da    <= '0;
      o_rpt_prior <= '0;
      o_rpt_len   <= '0;
      o_rpt_beats <= '0;
      o_rpt_err   <= '0;
      o_pkt_cnt   <= '0;
      o_err_cnt   <= '0;
      o_stray_cnt <= '0;
    end else begin
      ctx_q     <= ctx_n;
      o_rpt_vld <= fire;
      if (fire) begin
        o_rpt_da    <= ctx_n.da;
        o_rpt_prior <= ctx_n.prior;
        o_rpt_len   <= ctx_n.len;
        o_rpt_beats <= ctx_n.beats;
        o_rpt_err   <= err_n;
        o_pkt_cnt   <= sat_add(o_pkt_cnt, 2'd1);
      end
      // truncation and an erroneous single-beat report can land on the same cycle
      o_err_cnt <= sat_add(o_err_cnt, err_inc);
      if (stray) o_stray_cnt <= sat_add(o_stray_cnt, 2'd1);
    end
  end

endmodule

// File: tb/tb_data_chk.sv
// Bench for data_chk: directed vector table, reset/saturation sequences and randomized
// packet traffic checked against a packet-level reference model.
module tb_data_chk;
  localparam int DW = 32;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          sop = 1'b0, vld = 1'b0, eop = 1'b0;
  logic [DW-1:0] data = '0;

  logic        rpt_vld, b_rpt_vld;
  logic [3:0]  rpt_da, b_rpt_da, rpt_err, b_rpt_err;
  logic [2:0]  rpt_prior, b_rpt_prior;
  logic [9:0]  rpt_len, b_rpt_len;
  logic [10:0] rpt_beats, b_rpt_beats;
  logic [15:0] pkt_cnt, err_cnt, stray_cnt, b_pkt_cnt, b_err_cnt, b_stray_cnt;

  always #5 clk = ~clk;

  data_chk #(.DW(DW), .CHK_PAYLOAD(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_sop(sop), .i_vld(vld), .i_data(data), .i_eop(eop),
    .o_rpt_vld(rpt_vld), .o_rpt_da(rpt_da), .o_rpt_prior(rpt_prior), .o_rpt_len(rpt_len),
    .o_rpt_beats(rpt_beats), .o_rpt_err(rpt_err), .o_pkt_cnt(pkt_cnt), .o_err_cnt(err_cnt),
    .o_stray_cnt(stray_cnt));

  data_chk #(.DW(DW), .CHK_PAYLOAD(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_sop(sop), .i_vld(vld), .i_data(data), .i_eop(eop),
    .o_rpt_vld(b_rpt_vld), .o_rpt_da(b_rpt_da), .o_rpt_prior(b_rpt_prior), .o_rpt_len(b_rpt_len),
    .o_rpt_beats(b_rpt_beats), .o_rpt_err(b_rpt_err), .o_pkt_cnt(b_pkt_cnt), .o_err_cnt(b_err_cnt),
    .o_stray_cnt(b_stray_cnt));

  int n_cmp = 0, n_fail = 0;

  // reference model: collects whole packets, evaluates them at eop
  bit            in_pkt;
  logic [DW-1:0] pkt[$];
  logic          m_vld;
  logic [3:0]    m_da, m_err, m_err0;
  logic [2:0]    m_prior;
  logic [9:0]    m_len;
  logic [10:0]   m_beats;
  int            m_pkt, m_errc, m_errc0, m_stray;

  function automatic int sat16(input int x);
    return (x > 65535) ? 65535 : x;
  endfunction

  function automatic logic [DW-1:0] hdr(input int da, input int pr, input int len);
    return DW'(len * 128 + pr * 16 + da);
  endfunction

  task automatic model_reset();
    in_pkt = 0; pkt.delete();
    m_vld = 0; m_da = 0; m_err = 0; m_err0 = 0; m_prior = 0; m_len = 0; m_beats = 0;
    m_pkt = 0; m_errc = 0; m_errc0 = 0; m_stray = 0;
  endtask

  task automatic model_finish();
    int  len, nb;
    bit  bad;
    len = int'(pkt[0][16:7]);
    nb  = pkt.size();
    bad = 0;
    for (int j = 1; j < nb && j < len; j++)
      if (pkt[j] != DW'(j)) bad = 1;
    m_da    = pkt[0][3:0];
    m_prior = pkt[0][6:4];
    m_len   = pkt[0][16:7];
    m_beats = 11'((nb > 2047) ? 2047 : nb);
    m_err   = {len == 0, bad, (len != 0) && (nb > len), (len != 0) && (nb < len)};
    m_err0  = m_err & 4'b1011;
    m_vld   = 1;
    m_pkt   = sat16(m_pkt + 1);
    if (m_err != 0)  m_errc  = sat16(m_errc + 1);
    if (m_err0 != 0) m_errc0 = sat16(m_errc0 + 1);
    in_pkt = 0;
  endtask

  task automatic model_apply(input logic s, input logic v, input logic [DW-1:0] d, input logic e);
    m_vld = 0;
    if (v) begin
      if (s) begin
        if (in_pkt) begin
          m_errc  = sat16(m_errc + 1);
          m_errc0 = sat16(m_errc0 + 1);
        end
        pkt.delete();
        pkt.push_back(d);
        in_pkt = 1;
        if (e) model_finish();
      end else if (in_pkt) begin
        pkt.push_back(d);
        if (e) model_finish();
      end else begin
        m_stray = sat16(m_stray + 1);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("rpt_vld",   32'(rpt_vld),   32'(m_vld));
    chk("rpt_da",    32'(rpt_da),    32'(m_da));
    chk("rpt_prior", 32'(rpt_prior), 32'(m_prior));
    chk("rpt_len",   32'(rpt_len),   32'(m_len));
    chk("rpt_beats", 32'(rpt_beats), 32'(m_beats));
    chk("rpt_err",   32'(rpt_err),   32'(m_err));
    chk("pkt_cnt",   32'(pkt_cnt),   32'(m_pkt));
    chk("err_cnt",   32'(err_cnt),   32'(m_errc));
    chk("stray_cnt", 32'(stray_cnt), 32'(m_stray));
    chk("nochk_vld",     32'(b_rpt_vld), 32'(m_vld));
    chk("nochk_err",     32'(b_rpt_err), 32'(m_err0));
    chk("nochk_err_cnt", 32'(b_err_cnt), 32'(m_errc0));
  endtask

  // inputs change 1 time unit after a rising edge; outputs are sampled at the same point
  task automatic step(input logic s, input logic v, input logic e, input logic [DW-1:0] d);
    sop = s; vld = v; eop = e; data = d;
    @(posedge clk);
    #1;
    model_apply(s, v, d, e);
    check_model();
  endtask

  typedef struct {
    logic          s, v, e;
    logic [DW-1:0] d;
    logic          xv;
    logic [3:0]    xe;
    int            xp, xec;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic v, input logic e, input logic [DW-1:0] d,
                              input logic xv, input logic [3:0] xe, input int xp, input int xec);
    vec_t r;
    r.s = s; r.v = v; r.e = e; r.d = d; r.xv = xv; r.xe = xe; r.xp = xp; r.xec = xec;
    return r;
  endfunction

  vec_t tbl[30];

  initial begin
    int len, nb, gap, cut;

    // s v e data            vld err pkt errc
    tbl[0]  = mk(1, 1, 0, hdr(5, 3, 4), 0, 4'h0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 32'd1,        0, 4'h0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 32'd2,        0, 4'h0, 0, 0);
    tbl[3]  = mk(0, 1, 1, 32'd3,        1, 4'h0, 1, 0);
    tbl[4]  = mk(0, 0, 0, 32'd0,        0, 4'h0, 1, 0);
    tbl[5]  = mk(1, 1, 1, hdr(0, 0, 1), 1, 4'h0, 2, 0);
    tbl[6]  = mk(1, 1, 0, hdr(0, 0, 3), 0, 4'h0, 2, 0);
    tbl[7]  = mk(0, 1, 0, 32'd1,        0, 4'h0, 2, 0);
    tbl[8]  = mk(0, 1, 1, 32'd2,        1, 4'h0, 3, 0);
    tbl[9]  = mk(1, 1, 0, hdr(1, 2, 4), 0, 4'h0, 3, 0);
    tbl[10] = mk(0, 1, 0, 32'd1,        0, 4'h0, 3, 0);
    tbl[11] = mk(0, 1, 1, 32'd2,        1, 4'h1, 4, 1);
    tbl[12] = mk(1, 1, 0, hdr(2, 1, 2), 0, 4'h0, 4, 1);
    tbl[13] = mk(0, 1, 0, 32'd1,        0, 4'h0, 4, 1);
    tbl[14] = mk(0, 1, 1, 32'd2,        1, 4'h2, 5, 2);
    tbl[15] = mk(1, 1, 0, hdr(3, 7, 5), 0, 4'h0, 5, 2);
    tbl[16] = mk(0, 1, 0, 32'd1,        0, 4'h0, 5, 2);
    tbl[17] = mk(0, 1, 0, 32'd2,        0, 4'h0, 5, 2);
    tbl[18] = mk(0, 1, 0, 32'd9,        0, 4'h0, 5, 2);
    tbl[19] = mk(0, 1, 1, 32'd4,        1, 4'h4, 6, 3);
    tbl[20] = mk(1, 1, 0, hdr(4, 0, 6), 0, 4'h0, 6, 3);
    tbl[21] = mk(0, 1, 0, 32'd1,        0, 4'h0, 6, 3);
    tbl[22] = mk(0, 1, 0, 32'd2,        0, 4'h0, 6, 3);
    tbl[23] = mk(1, 1, 0, hdr(6, 5, 2), 0, 4'h0, 6, 4);
    tbl[24] = mk(0, 1, 1, 32'd1,        1, 4'h0, 7, 4);
    tbl[25] = mk(0, 1, 0, 32'd7,        0, 4'h0, 7, 4);
    tbl[26] = mk(0, 1, 1, 32'd8,        0, 4'h0, 7, 4);
    tbl[27] = mk(0, 1, 0, 32'd9,        0, 4'h0, 7, 4);
    tbl[28] = mk(0, 0, 0, 32'd0,        0, 4'h0, 7, 4);
    tbl[29] = mk(1, 1, 1, hdr(0, 0, 0), 1, 4'h8, 8, 5);

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model();
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].e, tbl[i].d);
      chk("tbl_vld", 32'(rpt_vld), 32'(tbl[i].xv));
      if (tbl[i].xv) chk("tbl_err", 32'(rpt_err), 32'(tbl[i].xe));
      chk("tbl_pkt_cnt", 32'(pkt_cnt), 32'(tbl[i].xp));
      chk("tbl_err_cnt", 32'(err_cnt), 32'(tbl[i].xec));
    end
    chk("tbl_stray_cnt", 32'(stray_cnt), 32'd3);

    // reset in the middle of a len=8 packet, remainder sent without sop
    step(1, 1, 0, hdr(1, 1, 8));
    step(0, 1, 0, 32'd1);
    step(0, 1, 0, 32'd2);
    vld = 1'b0; sop = 1'b0; eop = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int j = 3; j < 8; j++) step(0, 1, j == 7, DW'(j));
    step(0, 0, 0, '0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rst_stray_cnt", 32'(stray_cnt), 32'd5);

    // randomized traffic: bad lengths, payload errors, bubbles, truncation, strays
    for (int p = 0; p < 300; p++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++)
        step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, $urandom);
      len = $urandom_range(0, 8);
      nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : ((len == 0) ? 1 : len);
      cut = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : 100;
      for (int j = 0; j < nb && j < cut; j++) begin
        if (j > 0 && $urandom_range(0, 4) == 0) step(0, 0, 0, $urandom);
        step(j == 0, 1, j == nb - 1,
             (j == 0) ? hdr($urandom_range(0, 15), $urandom_range(0, 7), len)
                      : (($urandom_range(0, 9) == 0) ? DW'($urandom) : DW'(j)));
      end
    end

    // beat counter saturation on an overlong packet
    step(1, 1, 0, hdr(2, 2, 1023));
    for (int j = 1; j < 2100; j++) step(0, 1, j == 2099, DW'(j));
    chk("sat_beats", 32'(rpt_beats), 32'd2047);
    chk("sat_err", 32'(rpt_err), 32'h2);
    repeat (3) step(0, 0, 0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
